// File: rtl/i2c_slave_sequencer.sv
// I2C slave transaction sequencer: START/STOP, address match, address ACK.
// Optional I2C_GENERAL_CALL_EN also accepts address byte 8'h00 as a write.
module i2c_slave_sequencer #(
   parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
   input  logic       FPGA_clk,
   input  logic       rst,
   input  logic       SCL,
   input  logic       SDA,
   input  logic       din_done,
   output logic       din_enable,
   output logic       dout_enable,
   output logic       SDA_down,
   output logic [6:0] rx_addr,
   output logic       rw,
   output logic       start_pulse,
   output logic       stop_pulse,
   output logic       busy,
   output logic       gc_hit
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WRITE,
      READ,
      IGNORE
   } state_t;

   state_t     state;
   state_t     state_n;
   logic       SCL_prev;
   logic       SDA_prev;
   logic [7:0] shift_q;
   logic [7:0] shift_n;
   logic [3:0] bit_cnt;
   logic [3:0] bit_cnt_n;
   logic [6:0] rx_addr_n;
   logic       rw_n;
   logic       gc_q;
   logic       gc_n;
   logic       start_n;
   logic       stop_n;

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;
   logic addr_match;
   logic gc_match;

   assign scl_rise   = SCL & ~SCL_prev;
   assign scl_fall   = ~SCL & SCL_prev;
   assign start_det  = SCL & SCL_prev & SDA_prev & ~SDA;
   assign stop_det   = SCL & SCL_prev & ~SDA_prev & SDA;
   assign addr_match = (shift_q[7:1] == SLAVE_ADDR);

`ifdef I2C_GENERAL_CALL_EN
   assign gc_match = (shift_q == 8'h00);
`else
   assign gc_match = 1'b0;
`endif

   always_comb begin
      state_n   = state;
      shift_n   = shift_q;
      bit_cnt_n = bit_cnt;
      rx_addr_n = rx_addr;
      rw_n      = rw;
      gc_n      = gc_q;
      start_n   = 1'b0;
      stop_n    = 1'b0;
      if (stop_det) begin
         state_n = IDLE;
         stop_n  = 1'b1;
         gc_n    = 1'b0;
      end else if (start_det) begin
         state_n   = ADDR;
         shift_n   = 8'h00;
         bit_cnt_n = 4'd0;
         start_n   = 1'b1;
         gc_n      = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
            end
            ADDR: begin
               if (bit_cnt == 4'd8) begin
                  // decision waits for the fall so the ACK starts in SCL low
                  if (scl_fall) begin
                     if (addr_match || gc_match) begin
                        state_n   = ADDR_ACK;
                        rx_addr_n = shift_q[7:1];
                        rw_n      = shift_q[0];
                        gc_n      = gc_match;
                     end else begin
                        state_n = IGNORE;
                     end
                  end
               end else if (scl_rise) begin
                  shift_n   = {shift_q[6:0], SDA};
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  state_n = rw ? READ : WRITE;
               end
            end
            WRITE: begin
               if (din_done) begin
                  state_n = IDLE;
                  gc_n    = 1'b0;
               end
            end
            READ, IGNORE: begin
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge FPGA_clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         SCL_prev    <= 1'b1;
         SDA_prev    <= 1'b1;
         shift_q     <= 8'h00;
         bit_cnt     <= 4'd0;
         gc_q        <= 1'b0;
         rx_addr     <= 7'h00;
         rw          <= 1'b0;
         start_pulse <= 1'b0;
         stop_pulse  <= 1'b0;
         SDA_down    <= 1'b0;
         din_enable  <= 1'b0;
         dout_enable <= 1'b0;
         busy        <= 1'b0;
         gc_hit      <= 1'b0;
      end else begin
         state       <= state_n;
         SCL_prev    <= SCL;
         SDA_prev    <= SDA;
         shift_q     <= shift_n;
         bit_cnt     <= bit_cnt_n;
         gc_q        <= gc_n;
         rx_addr     <= rx_addr_n;
         rw          <= rw_n;
         start_pulse <= start_n;
         stop_pulse  <= stop_n;
         SDA_down    <= (state_n == ADDR_ACK);
         din_enable  <= (state_n == WRITE);
         dout_enable <= (state_n == READ);
         busy        <= (state_n != IDLE);
         gc_hit      <= gc_n & (state_n == WRITE);
      end
   end

endmodule

// File: tb/tb_i2c_slave_sequencer.sv
// Scoreboard bench for i2c_slave_sequencer: bus master tasks push expected
// output events, a monitor pops and compares them as the DUT produces them.
module tb_i2c_slave_sequencer;

   localparam int T = 5;
   localparam int ACK_W = 2 * T + 1;

   localparam int EV_BUSY  = 0;
   localparam int EV_ACK   = 1;
   localparam int EV_DIN   = 2;
   localparam int EV_DOUT  = 3;
   localparam int EV_DINF  = 4;
   localparam int EV_DOUTF = 5;
   localparam int EV_START = 6;
   localparam int EV_STOP  = 7;
   localparam int EV_IDLE  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       din_done = 1'b0;
   logic       sda_bus;
   logic       din_enable;
   logic       dout_enable;
   logic       SDA_down;
   logic [6:0] rx_addr;
   logic       rw;
   logic       start_pulse;
   logic       stop_pulse;
   logic       busy;
   logic       gc_hit;

   typedef struct {
      int k;
      int a;
      int b;
   } ev_t;

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;
   int  overlap = 0;
   bit  mon_en = 1'b0;

   logic p_busy = 1'b0;
   logic p_sda = 1'b0;
   logic p_din = 1'b0;
   logic p_dout = 1'b0;
   logic p_st = 1'b0;
   logic p_sp = 1'b0;
   int   ack_w = 0;
   int   st_w = 0;
   int   sp_w = 0;

   assign sda_bus = sda_m & ~SDA_down;

   always #5 clk = ~clk;

   i2c_slave_sequencer #(.SLAVE_ADDR(7'h42)) dut (
      .FPGA_clk   (clk),
      .rst        (rst),
      .SCL        (scl),
      .SDA        (sda_bus),
      .din_done   (din_done),
      .din_enable (din_enable),
      .dout_enable(dout_enable),
      .SDA_down   (SDA_down),
      .rx_addr    (rx_addr),
      .rw         (rw),
      .start_pulse(start_pulse),
      .stop_pulse (stop_pulse),
      .busy       (busy),
      .gc_hit     (gc_hit)
   );

   task automatic exp_ev(input int k, input int a, input int b);
      ev_t e;
      e.k = k;
      e.a = a;
      e.b = b;
      q.push_back(e);
   endtask

   task automatic got(input int k, input int a, input int b);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected event: got k=%0d a=%0h b=%0h, queue empty",
                  k, a, b);
      end else begin
         e = q.pop_front();
         if (e.k != k || e.a != a || e.b != b) begin
            errors++;
            $display("FAIL event: got k=%0d a=%0h b=%0h, want k=%0d a=%0h b=%0h",
                     k, a, b, e.k, e.a, e.b);
         end
      end
   endtask

   task automatic chk_idle(input string name);
      logic [15:0] v;
      v = {din_enable, dout_enable, SDA_down, rx_addr, rw,
           start_pulse, stop_pulse, busy, gc_hit};
      checks++;
      if (v != 16'h0000) begin
         errors++;
         $display("FAIL %s: outputs=%04h, want 0000", name, v);
      end
   endtask

   // monitor: turns output transitions into events for the scoreboard
   initial begin
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (din_enable && dout_enable) overlap++;
         if (busy && !p_busy) got(EV_BUSY, 0, 0);
         if (SDA_down) ack_w++;
         else if (p_sda) begin
            got(EV_ACK, ack_w, 0);
            ack_w = 0;
         end
         if (din_enable && !p_din)
            got(EV_DIN, int'({rx_addr, rw}), int'({gc_hit, p_sda & ~SDA_down}));
         if (dout_enable && !p_dout)
            got(EV_DOUT, int'({rx_addr, rw}), int'({gc_hit, p_sda & ~SDA_down}));
         if (!din_enable && p_din)
            got(EV_DINF, int'({start_pulse, stop_pulse}), int'(gc_hit));
         if (!dout_enable && p_dout)
            got(EV_DOUTF, int'({start_pulse, stop_pulse}), int'(gc_hit));
         if (start_pulse) st_w++;
         else if (p_st) begin
            got(EV_START, st_w, 0);
            st_w = 0;
         end
         if (stop_pulse) sp_w++;
         else if (p_sp) begin
            got(EV_STOP, sp_w, 0);
            sp_w = 0;
         end
         if (!busy && p_busy) got(EV_IDLE, int'(gc_hit), 0);
         p_busy = busy;
         p_sda  = SDA_down;
         p_din  = din_enable;
         p_dout = dout_enable;
         p_st   = start_pulse;
         p_sp   = stop_pulse;
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      wait_n(1);
      sda_m = b;
      wait_n(T);
      scl = 1'b1;
      wait_n(T);
      scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
   endtask

   task automatic i2c_start();
      wait_n(1);
      sda_m = 1'b1;
      wait_n(T);
      scl = 1'b1;
      wait_n(T);
      sda_m = 1'b0;
      wait_n(T);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_n(1);
      sda_m = 1'b0;
      wait_n(T);
      scl = 1'b1;
      wait_n(T);
      sda_m = 1'b1;
      wait_n(T);
   endtask

   task automatic addr_phase(input logic [7:0] d);
      send_byte(d);
      send_bit(1'b1);
   endtask

   initial begin
      wait_n(2);
      rst = 1'b1;
      wait_n(3);
      chk_idle("reset_hold");
      rst = 1'b0;
      wait_n(5);
      chk_idle("reset_release");
      mon_en = 1'b1;
      wait_n(2);

      // write to own address, a data byte, STOP
      exp_ev(EV_BUSY, 0, 0);
      exp_ev(EV_START, 1, 0);
      i2c_start();
      exp_ev(EV_ACK, ACK_W, 0);
      exp_ev(EV_DIN, 'h84, 1);
      addr_phase(8'h84);
      send_byte(8'h5A);
      exp_ev(EV_DINF, 1, 0);
      exp_ev(EV_IDLE, 0, 0);
      exp_ev(EV_STOP, 1, 0);
      i2c_stop();

      // read from own address
      exp_ev(EV_BUSY, 0, 0);
      exp_ev(EV_START, 1, 0);
      i2c_start();
      exp_ev(EV_ACK, ACK_W, 0);
      exp_ev(EV_DOUT, 'h85, 1);
      addr_phase(8'h85);
      exp_ev(EV_DOUTF, 1, 0);
      exp_ev(EV_IDLE, 0, 0);
      exp_ev(EV_STOP, 1, 0);
      i2c_stop();

      // foreign address: no ACK, stays busy until STOP
      exp_ev(EV_BUSY, 0, 0);
      exp_ev(EV_START, 1, 0);
      i2c_start();
      addr_phase(8'hA0);
      exp_ev(EV_IDLE, 0, 0);
      exp_ev(EV_STOP, 1, 0);
      i2c_stop();

      // repeated START in WRITE turning into a read
      exp_ev(EV_BUSY, 0, 0);
      exp_ev(EV_START, 1, 0);
      i2c_start();
      exp_ev(EV_ACK, ACK_W, 0);
      exp_ev(EV_DIN, 'h84, 1);
      addr_phase(8'h84);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      exp_ev(EV_DINF, 2, 0);
      exp_ev(EV_START, 1, 0);
      i2c_start();
      exp_ev(EV_ACK, ACK_W, 0);
      exp_ev(EV_DOUT, 'h85, 1);
      addr_phase(8'h85);
      exp_ev(EV_DOUTF, 1, 0);
      exp_ev(EV_IDLE, 0, 0);
      exp_ev(EV_STOP, 1, 0);
      i2c_stop();

      // general call
      exp_ev(EV_BUSY, 0, 0);
      exp_ev(EV_START, 1, 0);
      i2c_start();
`ifdef I2C_GENERAL_CALL_EN
      exp_ev(EV_ACK, ACK_W, 0);
      exp_ev(EV_DIN, 'h00, 3);
      addr_phase(8'h00);
      exp_ev(EV_DINF, 1, 0);
      exp_ev(EV_IDLE, 0, 0);
      exp_ev(EV_STOP, 1, 0);
      i2c_stop();
`else
      addr_phase(8'h00);
      exp_ev(EV_IDLE, 0, 0);
      exp_ev(EV_STOP, 1, 0);
      i2c_stop();
`endif

      // din_done ends the write early, later STOP only pulses
      exp_ev(EV_BUSY, 0, 0);
      exp_ev(EV_START, 1, 0);
      i2c_start();
      exp_ev(EV_ACK, ACK_W, 0);
      exp_ev(EV_DIN, 'h84, 1);
      addr_phase(8'h84);
      exp_ev(EV_DINF, 0, 0);
      exp_ev(EV_IDLE, 0, 0);
      wait_n(2);
      din_done = 1'b1;
      wait_n(1);
      din_done = 1'b0;
      wait_n(3);
      exp_ev(EV_STOP, 1, 0);
      i2c_stop();

      // reset in the middle of a write; bus activity afterwards ignored
      exp_ev(EV_BUSY, 0, 0);
      exp_ev(EV_START, 1, 0);
      i2c_start();
      exp_ev(EV_ACK, ACK_W, 0);
      exp_ev(EV_DIN, 'h84, 1);
      addr_phase(8'h84);
      send_bit(1'b0);
      send_bit(1'b1);
      exp_ev(EV_DINF, 0, 0);
      exp_ev(EV_IDLE, 0, 0);
      wait_n(1);
      rst = 1'b1;
      wait_n(3);
      chk_idle("reset_mid");
      rst = 1'b0;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      exp_ev(EV_STOP, 1, 0);
      i2c_stop();

      wait_n(20);
      while (q.size() != 0) begin
         ev_t e;
         e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing event: got none, want k=%0d a=%0h b=%0h",
                  e.k, e.a, e.b);
      end
      checks++;
      if (overlap != 0) begin
         errors++;
         $display("FAIL enable_overlap: got %0d cycles, want 0", overlap);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
